// File: rtl/rr_arb_hold.sv
// N-way round-robin arbiter with a registered one-hot grant and an optional
// hold mode that lets the owner keep the grant for bursts of up to MAX_HOLD cycles.
module rr_arb_hold #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             hold_en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             valid;
  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic             others;
  logic             below_max;
  logic             keep;
  int unsigned      pos;

  assign valid = |grant_q;

  // Circular search starting one past the last owner; the last owner is checked last.
  always_comb begin
    found   = 1'b0;
    win_idx = idx_q;
    pos     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = (int'(idx_q) + k) % N;
      if (!found && req[pos]) begin
        found   = 1'b1;
        win_idx = IDX_W'(pos);
      end
    end
  end

  assign others    = |(req & ~grant_q);
  assign below_max = (cnt_q < CNT_W'(MAX_HOLD - 1));
  assign keep      = hold_en && valid && req[idx_q] && (below_max || !others);

  always_comb begin
    grant_d = '0;
    idx_d   = idx_q;
    cnt_d   = '0;
    if (keep) begin
      grant_d = grant_q;
      cnt_d   = below_max ? cnt_q + CNT_W'(1) : cnt_q;
    end else if (found) begin
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
      idx_d            = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      grant_q <= '0;
      idx_q   <= IDX_W'(N - 1);
      cnt_q   <= '0;
    end else begin
      grant_q <= grant_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid;
  assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_arb_hold.sv
// Directed bench for rr_arb_hold: a 4-way and an 8-way instance, with expected
// grant/valid/index pushed to a scoreboard queue per step and checked after the edge.
module tb_rr_arb_hold;

  logic       clk;
  logic       a_rst_n, a_hold;
  logic [3:0] a_req, a_grant;
  logic       a_valid;
  logic [1:0] a_idx;
  logic       b_rst_n, b_hold;
  logic [7:0] b_req, b_grant;
  logic       b_valid;
  logic [2:0] b_idx;

  typedef struct {
    bit         sel;
    logic [7:0] g;
    logic       v;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stepn  = 0;

  rr_arb_hold #(.N(4), .IDX_W(2), .MAX_HOLD(4), .CNT_W(3)) u_dut4 (
    .clk         (clk),
    .areset_n    (a_rst_n),
    .hold_en     (a_hold),
    .req         (a_req),
    .grant       (a_grant),
    .grant_valid (a_valid),
    .grant_idx   (a_idx)
  );

  rr_arb_hold #(.N(8), .IDX_W(3), .MAX_HOLD(4), .CNT_W(3)) u_dut8 (
    .clk         (clk),
    .areset_n    (b_rst_n),
    .hold_en     (b_hold),
    .req         (b_req),
    .grant       (b_grant),
    .grant_valid (b_valid),
    .grant_idx   (b_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input bit sel, input logic rst_n, input logic hold,
                      input logic [7:0] r, input logic [7:0] eg, input logic [2:0] eidx);
    exp_t       e;
    logic [7:0] og;
    logic       ov;
    logic [2:0] oi;
    if (!sel) begin
      a_rst_n = rst_n;
      a_hold  = hold;
      a_req   = r[3:0];
    end else begin
      b_rst_n = rst_n;
      b_hold  = hold;
      b_req   = r;
    end
    e.sel = sel;
    e.g   = eg;
    e.v   = (eg != 8'h00);
    e.idx = eidx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    og = e.sel ? b_grant : {4'b0000, a_grant};
    ov = e.sel ? b_valid : a_valid;
    oi = e.sel ? b_idx : {1'b0, a_idx};
    checks++;
    assert (og === e.g) else begin
      errors++;
      $error("FAIL step%0d dut%0d grant observed=%h expected=%h", stepn, e.sel, og, e.g);
    end
    checks++;
    assert (ov === e.v) else begin
      errors++;
      $error("FAIL step%0d dut%0d grant_valid observed=%b expected=%b", stepn, e.sel, ov, e.v);
    end
    checks++;
    assert (oi === e.idx) else begin
      errors++;
      $error("FAIL step%0d dut%0d grant_idx observed=%0d expected=%0d", stepn, e.sel, oi, e.idx);
    end
    stepn++;
  endtask

  initial begin
    a_rst_n = 1'b0; a_hold = 1'b0; a_req = 4'h0;
    b_rst_n = 1'b0; b_hold = 1'b0; b_req = 8'h00;

    // 4-way: reset with all requesting, then per-cycle rotation
    repeat (2) step(0, 0, 0, 8'h0f, 8'h00, 3'd3);
    step(0, 1, 0, 8'h0f, 8'h01, 3'd0);
    step(0, 1, 0, 8'h0f, 8'h02, 3'd1);
    step(0, 1, 0, 8'h0f, 8'h04, 3'd2);
    step(0, 1, 0, 8'h0f, 8'h08, 3'd3);
    step(0, 1, 0, 8'h0f, 8'h01, 3'd0);

    // lone requester in both modes, then no requests keeps the index
    repeat (2) step(0, 1, 0, 8'h04, 8'h04, 3'd2);
    repeat (2) step(0, 1, 1, 8'h04, 8'h04, 3'd2);
    repeat (2) step(0, 1, 1, 8'h00, 8'h00, 3'd2);

    // hold mode bursts of four
    step(0, 0, 1, 8'h0f, 8'h00, 3'd3);
    repeat (4) step(0, 1, 1, 8'h0f, 8'h01, 3'd0);
    repeat (4) step(0, 1, 1, 8'h0f, 8'h02, 3'd1);
    repeat (4) step(0, 1, 1, 8'h0f, 8'h04, 3'd2);
    repeat (4) step(0, 1, 1, 8'h0f, 8'h08, 3'd3);
    repeat (2) step(0, 1, 1, 8'h0f, 8'h01, 3'd0);

    // owner drops after two cycles; new owner holds 4 with competition, forever alone
    step(0, 1, 1, 8'h08, 8'h08, 3'd3);
    repeat (3) step(0, 1, 1, 8'h09, 8'h08, 3'd3);
    step(0, 1, 1, 8'h09, 8'h01, 3'd0);
    repeat (6) step(0, 1, 1, 8'h08, 8'h08, 3'd3);

    // reset mid-burst (owner 2, counter 2), then counter restarts
    step(0, 0, 1, 8'h0f, 8'h00, 3'd3);
    step(0, 1, 1, 8'h04, 8'h04, 3'd2);
    repeat (2) step(0, 1, 1, 8'h0f, 8'h04, 3'd2);
    step(0, 0, 1, 8'h0f, 8'h00, 3'd3);
    repeat (4) step(0, 1, 1, 8'h0f, 8'h01, 3'd0);
    repeat (2) step(0, 1, 1, 8'h0f, 8'h02, 3'd1);

    // hold_en 1 -> 0 mid-burst rotates at once; back to 1 starts a fresh burst
    step(0, 1, 0, 8'h0f, 8'h04, 3'd2);
    step(0, 1, 0, 8'h0f, 8'h08, 3'd3);
    repeat (3) step(0, 1, 1, 8'h0f, 8'h08, 3'd3);
    step(0, 1, 1, 8'h0f, 8'h01, 3'd0);

    // 8-way: alternation between requesters 0 and 7, then hold bursts
    step(1, 0, 0, 8'h81, 8'h00, 3'd7);
    step(1, 1, 0, 8'h81, 8'h01, 3'd0);
    step(1, 1, 0, 8'h81, 8'h80, 3'd7);
    step(1, 1, 0, 8'h81, 8'h01, 3'd0);
    step(1, 1, 0, 8'h81, 8'h80, 3'd7);
    repeat (3) step(1, 1, 1, 8'h81, 8'h80, 3'd7);
    repeat (4) step(1, 1, 1, 8'h81, 8'h01, 3'd0);
    step(1, 1, 1, 8'h81, 8'h80, 3'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
